// File: rtl/bck_slot_scheduler.sv
// Issue/retire scheduler at the head of the backward-extension ring.
// Buffers read descriptors in a FIFO. It injects one descriptor into each ring
// slot that comes back free. It retires reads whose token returns finished,
// and it signals when a batch has fully drained.
//
// Handshake: a descriptor is transferred on a rising clk edge when req_valid
// and req_ready are both 1. req_ready depends only on registered FIFO
// occupancy, so it never depends on req_valid in the same cycle. While
// req_valid is 1 and req_ready is 0, the source must hold the descriptor
// stable. Pushes are accepted even while stall is 1.
module bck_slot_scheduler #(
  parameter int RNW        = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int PIPE_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [RNW-1:0] req_read_num,
  input  logic [6:0]     req_fwd_size,
  input  logic [6:0]     req_min_intv,
  input  logic [63:0]    req_primary,
  input  logic           batch_last,
  input  logic [5:0]     ret_status,
  input  logic           ret_finish,
  input  logic [RNW-1:0] ret_read_num,
  output logic           inj_take,
  output logic [5:0]     inj_status,
  output logic [RNW-1:0] inj_read_num,
  output logic [6:0]     inj_fwd_size,
  output logic [6:0]     inj_min_intv,
  output logic [63:0]    inj_primary,
  output logic           done_valid,
  output logic [RNW-1:0] done_read_num,
  output logic [3:0]     in_flight,
  output logic           batch_done,
  output logic           err_underflow,
  output logic [1:0]     dbg_state
);

  localparam logic [5:0] BUBBLE  = 6'b000000;
  localparam logic [5:0] BCK_INI = 6'b001000;
  localparam logic [5:0] BCK_RUN = 6'b010000;
  localparam logic [5:0] BCK_END = 6'b100000;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = RNW + 7 + 7 + 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Descriptor FIFO storage and pointers
  logic [DW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;
  logic           fifo_empty;

  logic [RNW-1:0] head_read_num;
  logic [6:0]     head_fwd_size;
  logic [6:0]     head_min_intv;
  logic [63:0]    head_primary;

  // Ring-side decisions for the token currently leaving the tail
  logic ret_retire;
  logic ret_free;
  logic retire;
  logic inject;
  logic dec;
  logic underflow;

  state_t state;
  state_t state_next;
  logic   last_latch;
  logic   last_latch_next;
  logic   eff_last;
  logic   batch_done_next;

  assign req_ready  = (count != CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = req_valid & req_ready;
  assign pop        = inject;
  assign dbg_state  = state;

  assign {head_read_num, head_fwd_size, head_min_intv, head_primary} = mem[rd_ptr];

  // A finished BCK_RUN token both retires a read and frees its slot.
  assign ret_retire = (ret_status == BCK_RUN) & ret_finish;
  assign ret_free   = (ret_status == BUBBLE) | (ret_status == BCK_END) | ret_retire;
  assign retire     = ~stall & ret_retire;
  assign dec        = retire & (in_flight != 4'd0);
  assign underflow  = retire & (in_flight == 4'd0);

  // A retiring slot makes room in the same cycle, so a full ring can still
  // swap one finished read for a new one.
  assign inject = ~stall & ret_free & ~fifo_empty &
                  ((state == ST_RUN) | (state == ST_DRAIN)) &
                  ((in_flight < 4'(PIPE_DEPTH)) | ret_retire);

  // FIFO write port; storage needs no reset because count gates the reads.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= {req_read_num, req_fwd_size, req_min_intv, req_primary};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Batch FSM and batch_last latch register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_latch <= 1'b0;
    end else begin
      state      <= state_next;
      last_latch <= last_latch_next;
    end
  end

  // Batch FSM next-state logic. A batch_last pulse counts in its own cycle.
  always_comb begin
    state_next      = state;
    batch_done_next = 1'b0;
    eff_last        = last_latch | batch_last;
    if (!stall) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_next = ST_RUN;
          end else if (eff_last && (in_flight == 4'd0)) begin
            batch_done_next = 1'b1;
          end
        end
        ST_RUN: begin
          if (eff_last && fifo_empty) state_next = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty && (in_flight == 4'd0)) begin
            state_next      = ST_IDLE;
            batch_done_next = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
    last_latch_next = eff_last & ~batch_done_next;
  end

  // Registered ring-head outputs; frozen entirely while the ring is stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inj_take      <= 1'b0;
      inj_status    <= BUBBLE;
      inj_read_num  <= '0;
      inj_fwd_size  <= '0;
      inj_min_intv  <= '0;
      inj_primary   <= '0;
      done_valid    <= 1'b0;
      done_read_num <= '0;
      in_flight     <= '0;
      batch_done    <= 1'b0;
      err_underflow <= 1'b0;
    end else if (!stall) begin
      inj_take   <= inject;
      inj_status <= inject ? BCK_INI : BUBBLE;
      if (inject) begin
        inj_read_num <= head_read_num;
        inj_fwd_size <= head_fwd_size;
        inj_min_intv <= head_min_intv;
        inj_primary  <= head_primary;
      end
      done_valid <= retire;
      if (retire) done_read_num <= ret_read_num;
      in_flight  <= in_flight + 4'(inject) - 4'(dec);
      batch_done <= batch_done_next;
      if (underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bck_slot_scheduler.sv
// Bench for bck_slot_scheduler: a table of vectors for the single-read flow,
// hand sequences for fill, swap, FIFO-full, stall and reset, then random
// traffic against a queue-based reference model.
module tb_bck_slot_scheduler;

  localparam logic [5:0] BUBBLE  = 6'b000000;
  localparam logic [5:0] BCK_INI = 6'b001000;
  localparam logic [5:0] BCK_RUN = 6'b010000;
  localparam logic [5:0] BCK_END = 6'b100000;

  typedef struct packed {
    logic [9:0]  rn;
    logic [6:0]  fwd;
    logic [6:0]  mi;
    logic [63:0] pr;
  } desc_t;

  typedef struct {
    logic       rv;
    logic [9:0] rn;
    logic [6:0] fwd;
    logic [5:0] rs;
    logic       rf;
    logic [9:0] rrn;
    logic       bl;
    logic       e_take;
    logic [9:0] e_inj_rn;
    logic       e_dv;
    logic [9:0] e_dn;
    logic [3:0] e_if;
    logic       e_bd;
  } vec_t;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, req_valid, req_ready, batch_last, ret_finish;
  logic [9:0]  req_read_num, ret_read_num, inj_read_num, done_read_num;
  logic [6:0]  req_fwd_size, req_min_intv, inj_fwd_size, inj_min_intv;
  logic [63:0] req_primary, inj_primary;
  logic [5:0]  ret_status, inj_status;
  logic        inj_take, done_valid, batch_done, err_underflow;
  logic [3:0]  in_flight;
  logic [1:0]  dbg_state;

  bck_slot_scheduler dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read_num(req_read_num), .req_fwd_size(req_fwd_size),
    .req_min_intv(req_min_intv), .req_primary(req_primary),
    .batch_last(batch_last),
    .ret_status(ret_status), .ret_finish(ret_finish), .ret_read_num(ret_read_num),
    .inj_take(inj_take), .inj_status(inj_status), .inj_read_num(inj_read_num),
    .inj_fwd_size(inj_fwd_size), .inj_min_intv(inj_min_intv), .inj_primary(inj_primary),
    .done_valid(done_valid), .done_read_num(done_read_num),
    .in_flight(in_flight), .batch_done(batch_done), .err_underflow(err_underflow),
    .dbg_state(dbg_state)
  );

  // reference model state
  desc_t exp_q[$];
  int    m_phase;   // 0 idle, 1 issuing, 2 draining
  int    m_flight;
  bit    m_latch;
  bit    e_take, e_dv, e_bd, e_err;
  logic [5:0] e_status;
  desc_t e_inj;
  logic [9:0] e_dn;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the behavioural model, from the rules for a ring slot.
  task automatic model_step();
    int sz;
    bit push, retire, free, inj, eff;
    desc_t d;
    if (!rst) begin
      exp_q.delete();
      m_phase = 0; m_flight = 0; m_latch = 0;
      e_take = 0; e_status = BUBBLE; e_inj = '0;
      e_dv = 0; e_dn = '0; e_bd = 0; e_err = 0;
    end else begin
      sz   = exp_q.size();
      push = req_valid && (sz < 16);
      if (stall) begin
        m_latch = m_latch || batch_last;
      end else begin
        retire = (ret_status == BCK_RUN) && ret_finish;
        free   = (ret_status == BUBBLE) || (ret_status == BCK_END) || retire;
        inj    = free && (sz > 0) && (m_phase != 0) && ((m_flight < 8) || retire);
        e_dv = retire;
        if (retire) e_dn = ret_read_num;
        if (retire && m_flight == 0) e_err = 1;
        eff  = m_latch || batch_last;
        e_bd = 0;
        if (m_phase == 0) begin
          if (sz > 0) m_phase = 1;
          else if (eff && m_flight == 0) e_bd = 1;
        end else if (m_phase == 1) begin
          if (eff && sz == 0) m_phase = 2;
        end else begin
          if (sz == 0 && m_flight == 0) begin
            m_phase = 0;
            e_bd = 1;
          end
        end
        m_latch = eff && !e_bd;
        if (inj) begin
          d = exp_q.pop_front();
          e_take = 1; e_status = BCK_INI; e_inj = d;
        end else begin
          e_take = 0; e_status = BUBBLE;
        end
        m_flight = m_flight + int'(inj) - int'(retire && m_flight > 0);
      end
      if (push) exp_q.push_back({req_read_num, req_fwd_size, req_min_intv, req_primary});
    end
  endtask

  task automatic compare_all();
    chk("inj_take", inj_take, e_take);
    chk("inj_status", inj_status, e_status);
    chk("inj_read_num", inj_read_num, e_inj.rn);
    chk("inj_fwd_size", inj_fwd_size, e_inj.fwd);
    chk("inj_min_intv", inj_min_intv, e_inj.mi);
    chk("inj_primary", inj_primary, e_inj.pr);
    chk("done_valid", done_valid, e_dv);
    chk("done_read_num", done_read_num, e_dn);
    chk("in_flight", in_flight, m_flight);
    chk("batch_done", batch_done, e_bd);
    chk("err_underflow", err_underflow, e_err);
    chk("req_ready", req_ready, exp_q.size() < 16);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    stall = 0; req_valid = 0; batch_last = 0;
    ret_status = BUBBLE; ret_finish = 0; ret_read_num = '0;
  endtask

  task automatic push_desc(input logic [9:0] rn);
    req_valid = 1; req_read_num = rn;
    req_fwd_size = 7'($urandom_range(0, 127));
    req_min_intv = 7'($urandom_range(0, 127));
    req_primary = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    idle_in();
    rst = 0;
    step();
    step();
    chk("reset_state", dbg_state, 2'd0);
    rst = 1;
  endtask

  vec_t t1[8];
  int takes;
  logic [5:0] codes[5];

  initial begin
    codes[0] = BUBBLE; codes[1] = BCK_INI; codes[2] = BCK_RUN;
    codes[3] = BCK_END; codes[4] = 6'b000011;
    //          rv    rn      fwd      rs       rf    rrn    bl    take  injrn  dv    dn     if    bd
    t1[0] = '{1'b1, 10'd5, 7'd101, BUBBLE,  1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 4'd0, 1'b0};
    t1[1] = '{1'b0, 10'd0, 7'd0,   BUBBLE,  1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 4'd0, 1'b0};
    t1[2] = '{1'b0, 10'd0, 7'd0,   BUBBLE,  1'b0, 10'd0, 1'b0, 1'b1, 10'd5, 1'b0, 10'd0, 4'd1, 1'b0};
    t1[3] = '{1'b0, 10'd0, 7'd0,   BUBBLE,  1'b0, 10'd0, 1'b0, 1'b0, 10'd5, 1'b0, 10'd0, 4'd1, 1'b0};
    t1[4] = '{1'b0, 10'd0, 7'd0,   BCK_RUN, 1'b1, 10'd5, 1'b0, 1'b0, 10'd5, 1'b1, 10'd5, 4'd0, 1'b0};
    t1[5] = '{1'b0, 10'd0, 7'd0,   BUBBLE,  1'b0, 10'd0, 1'b1, 1'b0, 10'd5, 1'b0, 10'd5, 4'd0, 1'b0};
    t1[6] = '{1'b0, 10'd0, 7'd0,   BUBBLE,  1'b0, 10'd0, 1'b0, 1'b0, 10'd5, 1'b0, 10'd5, 4'd0, 1'b1};
    t1[7] = '{1'b0, 10'd0, 7'd0,   BUBBLE,  1'b0, 10'd0, 1'b0, 1'b0, 10'd5, 1'b0, 10'd5, 4'd0, 1'b0};

    rst = 0; req_read_num = '0; req_fwd_size = '0; req_min_intv = '0; req_primary = '0;
    idle_in();

    // T1 single read, table driven
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_valid = t1[i].rv; req_read_num = t1[i].rn; req_fwd_size = t1[i].fwd;
      req_min_intv = 7'd3; req_primary = 64'h0123_4567_89ab_cdef;
      ret_status = t1[i].rs; ret_finish = t1[i].rf; ret_read_num = t1[i].rrn;
      batch_last = t1[i].bl;
      step();
      chk($sformatf("t1_take_%0d", i), inj_take, t1[i].e_take);
      chk($sformatf("t1_inj_rn_%0d", i), inj_read_num, t1[i].e_inj_rn);
      chk($sformatf("t1_done_%0d", i), done_valid, t1[i].e_dv);
      chk($sformatf("t1_done_rn_%0d", i), done_read_num, t1[i].e_dn);
      chk($sformatf("t1_in_flight_%0d", i), in_flight, t1[i].e_if);
      chk($sformatf("t1_batch_done_%0d", i), batch_done, t1[i].e_bd);
    end
    idle_in();

    // T2 fill the ring with 10 queued reads
    do_reset();
    takes = 0;
    for (int i = 0; i < 10; i++) begin
      push_desc(10'(100 + i));
      step();
      takes += int'(inj_take);
    end
    req_valid = 0;
    for (int i = 0; i < 4; i++) begin step(); takes += int'(inj_take); end
    ret_status = BCK_RUN;
    for (int i = 0; i < 4; i++) begin step(); takes += int'(inj_take); end
    chk("t2_inject_count", takes, 8);
    chk("t2_in_flight", in_flight, 4'd8);

    // T3 retire and inject in the same slot
    ret_status = BCK_RUN; ret_finish = 1; ret_read_num = 10'd2;
    step();
    chk("t3_done", done_valid, 1'b1);
    chk("t3_done_rn", done_read_num, 10'd2);
    chk("t3_take", inj_take, 1'b1);
    chk("t3_inj_rn", inj_read_num, 10'd108);
    chk("t3_in_flight", in_flight, 4'd8);
    idle_in();

    // T4 FIFO full while every slot is occupied
    do_reset();
    ret_status = BCK_INI;
    for (int i = 0; i < 17; i++) begin
      push_desc(10'(200 + i));
      step();
      if (i == 15) chk("t4_ready_full", req_ready, 1'b0);
    end
    req_valid = 0;
    step();
    ret_status = BUBBLE;
    step();
    chk("t4_take", inj_take, 1'b1);
    chk("t4_inj_rn", inj_read_num, 10'd200);
    chk("t4_ready_after_pop", req_ready, 1'b1);
    ret_status = BCK_INI;
    step();
    idle_in();

    // T5 stall with a free slot and a non-empty FIFO
    do_reset();
    ret_status = BCK_INI;
    for (int i = 0; i < 2; i++) begin push_desc(10'(300 + i)); step(); end
    req_valid = 0;
    for (int i = 0; i < 3; i++) step();
    stall = 1; ret_status = BUBBLE;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) push_desc(10'd302); else req_valid = 0;
      step();
      chk("t5_stall_take", inj_take, 1'b0);
      chk("t5_stall_in_flight", in_flight, 4'd0);
    end
    stall = 0; req_valid = 0;
    takes = 0;
    for (int i = 0; i < 4; i++) begin step(); takes += int'(inj_take); end
    chk("t5_inject_count", takes, 3);
    chk("t5_last_rn", inj_read_num, 10'd302);
    idle_in();

    // T6 reset with reads in flight and a retire pending
    do_reset();
    for (int i = 0; i < 4; i++) begin push_desc(10'(400 + i)); step(); end
    req_valid = 0;
    for (int i = 0; i < 2; i++) step();
    chk("t6_in_flight_before", in_flight, 4'd4);
    rst = 0; ret_status = BCK_RUN; ret_finish = 1; ret_read_num = 10'd400;
    step();
    chk("t6_in_flight", in_flight, 4'd0);
    chk("t6_inj_status", inj_status, BUBBLE);
    chk("t6_req_ready", req_ready, 1'b1);
    chk("t6_done", done_valid, 1'b0);
    rst = 1;
    idle_in();

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      stall = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) push_desc(10'($urandom_range(0, 1023)));
      else req_valid = 0;
      batch_last = ($urandom_range(0, 31) == 0);
      ret_status = codes[$urandom_range(0, 4)];
      ret_finish = 1'($urandom_range(0, 1));
      ret_read_num = 10'($urandom_range(0, 1023));
      step();
    end
    rst = 1;
    idle_in();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
